// File: rtl/rainbow_pattern_gen_pkg.sv
// Shared definitions for the rainbow pattern generator.
//   - hue arithmetic (11-bit hue, modulus 1536) and a wrap-safe adder
//   - colour-wheel sector encoding (hue[10:8])
//   - GRB byte offsets inside one 24-bit LED word
//   - sequencer state encoding
package rainbow_pattern_gen_pkg;

  localparam int          HUE_W   = 11;
  localparam logic [10:0] HUE_MOD = 11'd1536;

  localparam int GRB_W = 24;
  localparam int G_LSB = 16;
  localparam int R_LSB = 8;
  localparam int B_LSB = 0;

  typedef enum logic [2:0] {
    SEC_RED_TO_YEL = 3'd0,
    SEC_YEL_TO_GRN = 3'd1,
    SEC_GRN_TO_CYN = 3'd2,
    SEC_CYN_TO_BLU = 3'd3,
    SEC_BLU_TO_MAG = 3'd4,
    SEC_MAG_TO_RED = 3'd5
  } sector_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_RUN     = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;

  // Both operands are already reduced (< 1536), so one conditional
  // subtraction is enough to keep the result in 0..1535.
  function automatic logic [10:0] hue_add(input logic [10:0] a, input logic [10:0] b);
    logic [11:0] sum_s;
    sum_s = {1'b0, a} + {1'b0, b};
    if (sum_s >= {1'b0, HUE_MOD}) begin
      hue_add = 11'(sum_s - {1'b0, HUE_MOD});
    end else begin
      hue_add = sum_s[10:0];
    end
  endfunction

endpackage

// File: rtl/rainbow_pattern_gen_hue_to_grb.sv
// Combinational colour wheel: 11-bit hue -> dimmed 24-bit GRB word.
// Ports:
//   hue  in  11  hue value 0..1535 (sector = hue[10:8], fraction = hue[7:0])
//   grb  out 24  {G, R, B}, each channel right-shifted by BRIGHT_SHIFT
module rainbow_pattern_gen_hue_to_grb
  import rainbow_pattern_gen_pkg::*;
#(
  parameter int BRIGHT_SHIFT = 2
) (
  input  logic [10:0] hue,
  output logic [23:0] grb
);

  logic [2:0] sector_s;
  logic [7:0] f_s;
  logic [7:0] r_s;
  logic [7:0] g_s;
  logic [7:0] b_s;

  assign sector_s = hue[10:8];
  assign f_s      = hue[7:0];

  // Full-scale channel values for the six wheel sectors.
  always_comb begin
    r_s = 8'd0;
    g_s = 8'd0;
    b_s = 8'd0;
    case (sector_s)
      SEC_RED_TO_YEL: begin r_s = 8'd255;        g_s = f_s;           b_s = 8'd0;          end
      SEC_YEL_TO_GRN: begin r_s = 8'd255 - f_s;  g_s = 8'd255;        b_s = 8'd0;          end
      SEC_GRN_TO_CYN: begin r_s = 8'd0;          g_s = 8'd255;        b_s = f_s;           end
      SEC_CYN_TO_BLU: begin r_s = 8'd0;          g_s = 8'd255 - f_s;  b_s = 8'd255;        end
      SEC_BLU_TO_MAG: begin r_s = f_s;           g_s = 8'd0;          b_s = 8'd255;        end
      SEC_MAG_TO_RED: begin r_s = 8'd255;        g_s = 8'd0;          b_s = 8'd255 - f_s;  end
      // Sectors 6/7 cannot occur for a reduced hue; emit black.
      default:        begin r_s = 8'd0;          g_s = 8'd0;          b_s = 8'd0;          end
    endcase
  end

  assign grb[G_LSB +: 8] = g_s >> BRIGHT_SHIFT;
  assign grb[R_LSB +: 8] = r_s >> BRIGHT_SHIFT;
  assign grb[B_LSB +: 8] = b_s >> BRIGHT_SHIFT;

endmodule

// File: rtl/rainbow_pattern_gen.sv
// Rotating rainbow source for the WS2812B sender (GRBSeq/Cycle/Go interface).
// One LED word is computed per clock into a shadow register; the complete
// frame is then committed to GRBSeq in a single edge, so the sender never
// sees a partially updated frame.
// Ports:
//   clk     in   1            system clock
//   reset   in   1            asynchronous, active-high reset
//   Go      in   1            start/pause request (rising edge used)
//   Cycle   in   1            one-clock pulse per completed strip frame
//   GRBSeq  out  24*NUM_LEDS  frame; LED k at [24*(NUM_LEDS-k)-1 -: 24]
//   Busy    out  1            high while a frame is being computed
module rainbow_pattern_gen
  import rainbow_pattern_gen_pkg::*;
#(
  parameter int NUM_LEDS        = 5,
  parameter int HUE_SPACING     = 256,
  parameter int HUE_STEP        = 16,
  parameter int FRAMES_PER_STEP = 4,
  parameter int BRIGHT_SHIFT    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Go,
  input  logic                      Cycle,
  output logic [24*NUM_LEDS-1:0]    GRBSeq,
  output logic                      Busy
);

  localparam int IDX_W = $clog2(NUM_LEDS + 1);
  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [10:0] SPACING_H = 11'(HUE_SPACING % 1536);
  localparam logic [10:0] STEP_H    = 11'(HUE_STEP % 1536);
  localparam int FRAME_W = GRB_W * NUM_LEDS;

  state_e               state_r;
  state_e               state_nxt_s;
  logic                 go_prev_r;
  logic                 go_edge_s;
  logic                 last_s;
  logic                 cnt_due_s;
  logic [10:0]          base_hue_r;
  logic [10:0]          base_nxt_s;
  logic [10:0]          stepped_base_s;
  logic [CNT_W-1:0]     frame_cnt_r;
  logic [CNT_W-1:0]     frame_nxt_s;
  logic                 pending_r;
  logic                 pending_nxt_s;
  logic                 go_seen_r;
  logic                 go_seen_nxt_s;
  logic [IDX_W-1:0]     idx_r;
  logic [IDX_W-1:0]     idx_nxt_s;
  logic [10:0]          cur_hue_r;
  logic [10:0]          hue_nxt_s;
  logic                 shadow_wr_s;
  logic                 commit_s;
  logic                 busy_nxt_s;
  logic [23:0]          led_grb_s;
  logic [FRAME_W-1:0]   shadow_r;
  logic [FRAME_W-1:0]   grb_r;
  logic                 busy_r;

  assign go_edge_s      = Go & ~go_prev_r;
  // idx_r counts written LEDs; reaching NUM_LEDS means the shadow is full.
  assign last_s         = (idx_r == LAST_IDX);
  assign cnt_due_s      = (frame_cnt_r == CNT_LAST);
  assign stepped_base_s = hue_add(base_hue_r, STEP_H);

  // Single colour-wheel instance shared by all LED slots.
  rainbow_pattern_gen_hue_to_grb #(
    .BRIGHT_SHIFT (BRIGHT_SHIFT)
  ) u_hue_to_grb (
    .hue (cur_hue_r),
    .grb (led_grb_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a Go edge always beats a coincident Cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (go_edge_s) state_nxt_s = ST_COMPUTE;
        else           state_nxt_s = ST_IDLE;
      end
      ST_COMPUTE: begin
        if (!last_s)                                  state_nxt_s = ST_COMPUTE;
        else if (go_seen_r || go_edge_s)              state_nxt_s = ST_HOLD;
        else if ((pending_r || Cycle) && cnt_due_s)   state_nxt_s = ST_COMPUTE;
        else                                          state_nxt_s = ST_RUN;
      end
      ST_RUN: begin
        if (go_edge_s)               state_nxt_s = ST_HOLD;
        else if (Cycle && cnt_due_s) state_nxt_s = ST_COMPUTE;
        else                         state_nxt_s = ST_RUN;
      end
      ST_HOLD: begin
        if (go_edge_s) state_nxt_s = ST_RUN;
        else           state_nxt_s = ST_HOLD;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath controls: next values of hue/counter/flag registers and strobes.
  always_comb begin
    base_nxt_s    = base_hue_r;
    frame_nxt_s   = frame_cnt_r;
    pending_nxt_s = pending_r;
    go_seen_nxt_s = go_seen_r;
    idx_nxt_s     = idx_r;
    hue_nxt_s     = cur_hue_r;
    shadow_wr_s   = 1'b0;
    commit_s      = 1'b0;
    busy_nxt_s    = (state_nxt_s == ST_COMPUTE);
    case (state_r)
      ST_IDLE: begin
        if (go_edge_s) begin
          base_nxt_s    = 11'd0;
          frame_nxt_s   = CNT_ZERO;
          pending_nxt_s = 1'b0;
          go_seen_nxt_s = 1'b0;
          idx_nxt_s     = IDX_ZERO;
          hue_nxt_s     = 11'd0;
        end else begin
          base_nxt_s = base_hue_r;
        end
      end
      ST_COMPUTE: begin
        if (last_s) begin
          commit_s      = 1'b1;
          pending_nxt_s = 1'b0;
          go_seen_nxt_s = 1'b0;
          idx_nxt_s     = IDX_ZERO;
          if (go_seen_r || go_edge_s) begin
            // Pausing takes priority; a retained Cycle is dropped.
            frame_nxt_s = frame_cnt_r;
          end else if (pending_r || Cycle) begin
            if (cnt_due_s) begin
              frame_nxt_s = CNT_ZERO;
              base_nxt_s  = stepped_base_s;
              hue_nxt_s   = stepped_base_s;
            end else begin
              frame_nxt_s = frame_cnt_r + CNT_ONE;
            end
          end else begin
            frame_nxt_s = frame_cnt_r;
          end
        end else begin
          shadow_wr_s = 1'b1;
          idx_nxt_s   = idx_r + IDX_ONE;
          hue_nxt_s   = hue_add(cur_hue_r, SPACING_H);
          if (Cycle) pending_nxt_s = 1'b1;
          else       pending_nxt_s = pending_r;
          if (go_edge_s) go_seen_nxt_s = 1'b1;
          else           go_seen_nxt_s = go_seen_r;
        end
      end
      ST_RUN: begin
        if (go_edge_s) begin
          frame_nxt_s = frame_cnt_r;
        end else if (Cycle) begin
          if (cnt_due_s) begin
            frame_nxt_s   = CNT_ZERO;
            base_nxt_s    = stepped_base_s;
            hue_nxt_s     = stepped_base_s;
            idx_nxt_s     = IDX_ZERO;
            pending_nxt_s = 1'b0;
            go_seen_nxt_s = 1'b0;
          end else begin
            frame_nxt_s = frame_cnt_r + CNT_ONE;
          end
        end else begin
          frame_nxt_s = frame_cnt_r;
        end
      end
      ST_HOLD: begin
        frame_nxt_s = frame_cnt_r;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath registers, shadow frame and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go_prev_r   <= 1'b0;
      base_hue_r  <= 11'd0;
      frame_cnt_r <= CNT_ZERO;
      pending_r   <= 1'b0;
      go_seen_r   <= 1'b0;
      idx_r       <= IDX_ZERO;
      cur_hue_r   <= 11'd0;
      shadow_r    <= {FRAME_W{1'b0}};
      grb_r       <= {FRAME_W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      go_prev_r   <= Go;
      base_hue_r  <= base_nxt_s;
      frame_cnt_r <= frame_nxt_s;
      pending_r   <= pending_nxt_s;
      go_seen_r   <= go_seen_nxt_s;
      idx_r       <= idx_nxt_s;
      cur_hue_r   <= hue_nxt_s;
      busy_r      <= busy_nxt_s;
      // LED 0 lives in the most significant word.
      for (int k = 0; k < NUM_LEDS; k++) begin
        if (shadow_wr_s && (idx_r == IDX_W'(k))) begin
          shadow_r[GRB_W*(NUM_LEDS-1-k) +: GRB_W] <= led_grb_s;
        end
      end
      if (commit_s) begin
        grb_r <= shadow_r;
      end
    end
  end

  assign GRBSeq = grb_r;
  assign Busy   = busy_r;

endmodule

// File: tb/tb_rainbow_pattern_gen.sv
module tb_rainbow_pattern_gen;

  localparam int N = 5;
  localparam int W = 24 * N;
  localparam int M_IDLE = 0, M_COMPUTE = 1, M_RUN = 2, M_HOLD = 3;

  localparam logic [W-1:0] FRAME0  = 120'h003F00_3F3F00_3F0000_3F003F_00003F;
  localparam logic [W-1:0] FRAME16 = 120'h043F00_3F3B00_3F0004_3B003F_00043F;
  localparam logic [23:0]  LED0_B16 = 24'h043F00;
  localparam logic [23:0]  LED0_B32 = 24'h083F00;

  logic clk = 1'b0;
  logic reset, go, cyc;
  logic [W-1:0] grb_s [3];
  logic         busy_s [3];

  always #5 clk = ~clk;

  // a: defaults; b: wrap-around step, one frame per step; c: one frame per step
  rainbow_pattern_gen #(.NUM_LEDS(N)) dut_a (
    .clk(clk), .reset(reset), .Go(go), .Cycle(cyc), .GRBSeq(grb_s[0]), .Busy(busy_s[0]));
  rainbow_pattern_gen #(.NUM_LEDS(N), .HUE_STEP(1520), .FRAMES_PER_STEP(1)) dut_b (
    .clk(clk), .reset(reset), .Go(go), .Cycle(cyc), .GRBSeq(grb_s[1]), .Busy(busy_s[1]));
  rainbow_pattern_gen #(.NUM_LEDS(N), .FRAMES_PER_STEP(1)) dut_c (
    .clk(clk), .reset(reset), .Go(go), .Cycle(cyc), .GRBSeq(grb_s[2]), .Busy(busy_s[2]));

  int n_checks = 0;
  int n_fail   = 0;

  int p_step [3] = '{16, 1520, 16};
  int p_fps  [3] = '{4, 1, 1};

  // Reference model state (per instance)
  int           m_mode [3];
  int           m_left [3];
  int           m_base [3];
  int           m_fc   [3];
  bit           m_pend [3];
  bit           m_gop  [3];
  bit           m_busy [3];
  logic [W-1:0] m_grb  [3];
  bit           m_go_prev;

  typedef struct {
    logic         go;
    logic         cyc;
    logic         exp_busy;
    logic [W-1:0] exp_grb;
  } vec_t;
  vec_t tbl [7];

  function automatic logic [23:0] wheel(input int hue);
    int sec, f, r, g, b;
    sec = hue / 256;
    f   = hue % 256;
    case (sec)
      0: begin r = 255;     g = f;       b = 0;       end
      1: begin r = 255 - f; g = 255;     b = 0;       end
      2: begin r = 0;       g = 255;     b = f;       end
      3: begin r = 0;       g = 255 - f; b = 255;     end
      4: begin r = f;       g = 0;       b = 255;     end
      default: begin r = 255; g = 0;     b = 255 - f; end
    endcase
    return {8'(g / 4), 8'(r / 4), 8'(b / 4)};
  endfunction

  function automatic logic [W-1:0] frame(input int base);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[24*(N-1-k) +: 24] = wheel((base + k * 256) % 1536);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = M_IDLE; m_left[i] = 0; m_base[i] = 0; m_fc[i] = 0;
      m_pend[i] = 0; m_gop[i] = 0; m_busy[i] = 0; m_grb[i] = '0;
    end
    m_go_prev = 0;
  endtask

  task automatic model_start(input int i);
    m_mode[i] = M_COMPUTE;
    m_left[i] = N + 1;
    m_busy[i] = 1;
  endtask

  // One counted frame: after FRAMES_PER_STEP of them the wheel advances.
  task automatic model_count(input int i);
    m_fc[i]++;
    if (m_fc[i] == p_fps[i]) begin
      m_fc[i]   = 0;
      m_base[i] = (m_base[i] + p_step[i]) % 1536;
      model_start(i);
    end
  endtask

  task automatic model_step();
    bit ge;
    if (reset) begin
      model_reset();
    end else begin
      ge = go && !m_go_prev;
      m_go_prev = go;
      for (int i = 0; i < 3; i++) begin
        case (m_mode[i])
          M_IDLE: if (ge) begin
            m_base[i] = 0; m_fc[i] = 0; m_pend[i] = 0; m_gop[i] = 0;
            model_start(i);
          end
          M_COMPUTE: begin
            m_left[i]--;
            if (m_left[i] == 0) begin
              m_grb[i]  = frame(m_base[i]);
              m_busy[i] = 0;
              m_mode[i] = M_RUN;
              if (m_gop[i] || ge) m_mode[i] = M_HOLD;
              else if (m_pend[i] || cyc) model_count(i);
              m_pend[i] = 0;
              m_gop[i]  = 0;
            end else begin
              if (cyc) m_pend[i] = 1;
              if (ge)  m_gop[i]  = 1;
            end
          end
          M_RUN: begin
            if (ge) m_mode[i] = M_HOLD;
            else if (cyc) model_count(i);
          end
          default: if (ge) m_mode[i] = M_RUN;
        endcase
      end
    end
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_grb[%0d]", i), grb_s[i], m_grb[i]);
      chk($sformatf("model_busy[%0d]", i), W'(busy_s[i]), W'(m_busy[i]));
    end
    n_checks++;
    if (dut_b.cur_hue_r >= 11'd1536) begin
      n_fail++;
      $display("FAIL hue_range: got %0d expected below 1536", dut_b.cur_hue_r);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic pulse_cycle();
    cyc = 1'b1; tick(); cyc = 1'b0; tick();
  endtask

  task automatic pulse_go();
    go = 1'b1; tick(); go = 1'b0; tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    for (int t = 0; t < 30 && busy_s[i]; t++) tick();
    n_checks++;
    if (busy_s[i]) begin
      n_fail++;
      $display("FAIL wait_idle[%0d]: got Busy=1 expected 0 within 30 clocks", i);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, {W{1'b0}}};
    for (int r = 1; r < 6; r++) tbl[r] = '{1'b0, 1'b0, 1'b1, {W{1'b0}}};
    tbl[6] = '{1'b0, 1'b0, 1'b0, FRAME0};

    reset = 1'b1; go = 1'b0; cyc = 1'b0;
    model_reset();
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("reset_grb", grb_s[i], {W{1'b0}});
      chk("reset_busy", W'(busy_s[i]), {W{1'b0}});
    end
    tick();
    reset = 1'b0;
    tick();

    // First frame: Busy for 6 clocks, no partial frame, then the base-0 rainbow
    for (int r = 0; r < 7; r++) begin
      go = tbl[r].go; cyc = tbl[r].cyc;
      tick();
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("tbl_busy[%0d][%0d]", r, i), W'(busy_s[i]), W'(tbl[r].exp_busy));
        chk($sformatf("tbl_grb[%0d][%0d]", r, i), grb_s[i], tbl[r].exp_grb);
      end
    end
    go = 1'b0;

    // Four frames advance the default instance by one step
    for (int p = 0; p < 4; p++) pulse_cycle();
    wait_idle(0);
    chk("step16_frame", grb_s[0], FRAME16);

    // Hold keeps the frame and the frame count
    pulse_cycle(); pulse_cycle();
    pulse_go();
    for (int p = 0; p < 10; p++) pulse_cycle();
    chk("hold_frame", grb_s[0], FRAME16);
    chk("hold_busy", W'(busy_s[0]), {W{1'b0}});
    pulse_go();
    pulse_cycle();
    chk("resume_no_step", W'(busy_s[0]), {W{1'b0}});
    pulse_cycle();
    chk("resume_step", W'(busy_s[0]), W'(1'b1));
    wait_idle(0);
    chk("step32_led0", W'(grb_s[0][W-1 -: 24]), W'(LED0_B32));

    // Reset in the middle of a computation
    pulse_reset();
    pulse_go();
    wait_idle(0);
    cyc = 1'b1; tick(); cyc = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      chk("midreset_grb", grb_s[i], {W{1'b0}});
      chk("midreset_busy", W'(busy_s[i]), {W{1'b0}});
    end
    tick();
    reset = 1'b0;
    pulse_go();
    wait_idle(0);
    for (int i = 0; i < 3; i++) chk("after_reset_frame", grb_s[i], FRAME0);

    // Cycle during computation, one frame per step: back-to-back recompute
    cyc = 1'b1; tick(); cyc = 1'b0;
    tick(); tick();
    cyc = 1'b1; tick(); cyc = 1'b0;
    tick(); tick(); tick();
    chk("pending_restart_busy", W'(busy_s[2]), W'(1'b1));
    chk("pending_first_frame", grb_s[2], FRAME16);
    wait_idle(2);
    chk("pending_second_led0", W'(grb_s[2][W-1 -: 24]), W'(LED0_B32));

    // Wrap: step of 1536-16; step 95 lands on base 16, step 96 on base 0
    pulse_reset();
    pulse_go();
    wait_idle(1);
    for (int s = 1; s <= 96; s++) begin
      pulse_cycle();
      wait_idle(1);
      if (s == 95) chk("wrap_base16_led0", W'(grb_s[1][W-1 -: 24]), W'(LED0_B16));
      if (s == 96) chk("wrap_base0_frame", grb_s[1], FRAME0);
    end

    // Random traffic against the model
    for (int t = 0; t < 1500; t++) begin
      go    = ($urandom_range(0, 39) == 0);
      cyc   = ($urandom_range(0, 3) == 0);
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    go = 1'b0; cyc = 1'b0; reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rainbow_pattern_gen.md
Name: rainbow_pattern_gen

Overview:
Upstream GRB pattern source for the WS2812B sender, an alternative to the cylon generator on the same GRBSeq/Cycle/Go interface. Produces a rotating rainbow, one hue per LED spaced evenly around a 6-sector colour wheel. The wheel advances once every FRAMES_PER_STEP frame-done pulses (Cycle). A small sequencer computes one LED per clock into a shadow register, then commits the whole frame atomically.

Parameters:
NUM_LEDS, 5, LEDs in strip; GRBSeq width = 24*NUM_LEDS
HUE_SPACING, 256, hue offset between adjacent LEDs (hue units, 0..1535)
HUE_STEP, 16, base-hue increment per step
FRAMES_PER_STEP, 4, Cycle pulses per base-hue step (>=1)
BRIGHT_SHIFT, 2, right-shift applied to every 8-bit channel (0..7)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
Go  input  1  start/pause request, rising-edge detected internally
Cycle  input  1  one-clock pulse per completed strip frame from the send state machine
GRBSeq  output  24*NUM_LEDS  frame pattern; LED k at bits [24*(NUM_LEDS-k)-1 -: 24], G[23:16] R[15:8] B[7:0]
Busy  output  1  high while a frame is being computed

Behaviour:
- Clock/reset: single clock clk. reset is asynchronous and active-high. On reset: GRBSeq=0, Busy=0, state IDLE, base_hue=0, frame_cnt=0, pending=0, Go edge register=0.
- Hue arithmetic: 11-bit, modulo 1536. Any sum >= 1536 subtracts 1536; never exceeds 1535. LED k hue = (base_hue + k*HUE_SPACING) mod 1536.
- Wheel: sector = hue[10:8] (0..5), f = hue[7:0].
  - Sector 0: R=255, G=f, B=0
  - Sector 1: R=255-f, G=255, B=0
  - Sector 2: R=0, G=255, B=f
  - Sector 3: R=0, G=255-f, B=255
  - Sector 4: R=f, G=0, B=255
  - Sector 5: R=255, G=0, B=255-f
  - Each channel is then >> BRIGHT_SHIFT.
- States: IDLE, COMPUTE, RUN, HOLD.
  - IDLE: GRBSeq held at 0. Cycle ignored. Go rising edge -> COMPUTE with base_hue=0.
  - COMPUTE: Busy=1. Edge detected at clock edge E0. Edges E1..E(NUM_LEDS) write LED 0..NUM_LEDS-1 into the shadow register. At edge E(NUM_LEDS+1), GRBSeq <= shadow, Busy<=0, state -> RUN. Latency from Go edge to new GRBSeq is NUM_LEDS+1 clocks. GRBSeq never shows a partial frame.
  - RUN: each Cycle pulse increments frame_cnt. When frame_cnt reaches FRAMES_PER_STEP-1 and Cycle is high: frame_cnt<=0, base_hue<=(base_hue+HUE_STEP) mod 1536, state -> COMPUTE. Go rising edge -> HOLD.
  - HOLD: GRBSeq frozen. Cycle ignored; frame_cnt kept. Go rising edge -> RUN.
- Simultaneous events:
  - Cycle pulse during COMPUTE sets pending. On commit, pending is consumed as one frame_cnt increment, with a step if due, and cleared. Only one pending Cycle is retained.
  - Go edge during COMPUTE is recorded. After commit, the state goes to HOLD instead of RUN.
  - Go edge and Cycle in the same clock in RUN: Go wins; Cycle is dropped.
- Reset mid-COMPUTE: GRBSeq returns to 0 immediately and the shadow is discarded.

Decomposition:
- Shared package: hue modulus 1536, sector encoding, GRB byte-offset constants, state encoding.
- One combinational sub-module hue_to_grb: 11-bit hue plus BRIGHT_SHIFT -> 24-bit GRB word. Instantiated once and time-shared by the sequencer.

Test Plan:
- Reset then Go pulse, defaults -> Busy high 6 clocks; then GRBSeq = 003F00_3F3F00_3F0000_3F003F_00003F (LED0 in the MSBs).
- From RUN, 4 Cycle pulses -> base_hue=16; recompute gives LED0 = 043F00 (f=16>>2=4).
- Hue wrap: HUE_STEP=1536-16, single step from base 16 -> base_hue=0 exactly, frame identical to the first frame; no value >= 1536 observed on the internal hue.
- Cycle pulse injected at COMPUTE clock 3, FRAMES_PER_STEP=1 -> after commit a second COMPUTE starts immediately; base_hue advanced twice in total.
- Go pulse in RUN, then 10 Cycle pulses -> GRBSeq unchanged, Busy=0. Second Go -> RUN; stepping resumes with frame_cnt preserved.
- Assert reset at COMPUTE clock 2 -> GRBSeq=0 and Busy=0 asynchronously. After release, Go reproduces the reset-frame value from the first scenario.
